// File: rtl/apu_pwr_seq_if.sv
// apu_pwr_seq_if
//   Board-side signal bundle of the APU power sequencer. osc and rst are not
//   part of the bundle; they remain plain ports on the sequencer.
//   slave  : sequencer side (sleep/power-good/control in, enables/status out)
//   master : board/host side (drives the inputs, observes the outputs)
// Signals:
//   ctrl_signal      CPLD init done; low forces the sequencer to OFF
//   SLP_S5n/SLP_S3n  CPU sleep-state indications
//   *_PWRGD          rail power-good inputs
//   vrm_allow        board strap gating APU_VRM_EN
//   fault_clr        single-cycle pulse that clears FAULT
//   EN_1V5, VRS_ON, V1V8_EN, APU_VRM_EN   rail enables
//   DISCHARGE_S5n/S3n                     low = discharge active
//   sys_pwrgd, pwr_rstn                   CPU power-good and platform reset
//   state[2:0], fault, fault_code[3:0]    status readback
interface apu_pwr_seq_if;
  logic       ctrl_signal;
  logic       SLP_S5n;
  logic       SLP_S3n;
  logic       V3V3_ALW_PWRGD;
  logic       V1V5_PWRGD;
  logic       V1V8_PWRGD;
  logic       V1V_PWRGD;
  logic       APU_VDD_PWRGD;
  logic       vrm_allow;
  logic       fault_clr;
  logic       EN_1V5;
  logic       VRS_ON;
  logic       V1V8_EN;
  logic       APU_VRM_EN;
  logic       DISCHARGE_S5n;
  logic       DISCHARGE_S3n;
  logic       sys_pwrgd;
  logic       pwr_rstn;
  logic [2:0] state;
  logic       fault;
  logic [3:0] fault_code;

  modport slave (
    input  ctrl_signal, SLP_S5n, SLP_S3n, V3V3_ALW_PWRGD, V1V5_PWRGD,
           V1V8_PWRGD, V1V_PWRGD, APU_VDD_PWRGD, vrm_allow, fault_clr,
    output EN_1V5, VRS_ON, V1V8_EN, APU_VRM_EN, DISCHARGE_S5n, DISCHARGE_S3n,
           sys_pwrgd, pwr_rstn, state, fault, fault_code
  );

  modport master (
    output ctrl_signal, SLP_S5n, SLP_S3n, V3V3_ALW_PWRGD, V1V5_PWRGD,
           V1V8_PWRGD, V1V_PWRGD, APU_VDD_PWRGD, vrm_allow, fault_clr,
    input  EN_1V5, VRS_ON, V1V8_EN, APU_VRM_EN, DISCHARGE_S5n, DISCHARGE_S3n,
           sys_pwrgd, pwr_rstn, state, fault, fault_code
  );
endinterface

// File: rtl/apu_pwr_seq.sv
// apu_pwr_seq
//   Registered power sequencer for the APU rails: OFF -> S5 -> S3 -> VRM ->
//   reset delay -> RUN, with per-stage power-good timeouts, a latched fault
//   code and platform reset release after RST_DLY cycles.
// Ports:
//   osc  sequencer clock (internal oscillator)
//   rst  asynchronous active-high reset
//   bus  apu_pwr_seq_if.slave: sleep/power-good/control inputs, rail enables,
//        discharge controls, sys_pwrgd, pwr_rstn and status readback
// Build option:
//   APU_PWR_RETRY_EN  when defined, FAULT auto-exits to OFF after RETRY_WAIT
//                     cycles, at most MAX_RETRY times in a row.
//
// state    | meaning
// ---------+-----------------------------------------------
// OFF      | all rails off, discharges active
// S5_EN    | 1V5 enabled, waiting for V1V5_PWRGD
// S5_OK    | S5 rails good, waiting for SLP_S3n
// S3_EN    | 1V8/VRS enabled, waiting for V1V8 and V1V good
// VRM_EN   | APU VRM enabled, waiting for APU_VDD_PWRGD
// RST_WAIT | all rails good, sys_pwrgd high, counting RST_DLY
// RUN      | platform reset released
// FAULT    | rails off, fault_code latched
module apu_pwr_seq #(
  parameter int STAGE_TMO  = 55600,
  parameter int RST_DLY    = 1112000,
  parameter int RETRY_WAIT = 5560000,
  parameter int MAX_RETRY  = 3
) (
  input  logic         osc,
  input  logic         rst,
  apu_pwr_seq_if.slave bus
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    S5_EN    = 3'd1,
    S5_OK    = 3'd2,
    S3_EN    = 3'd3,
    VRM_EN   = 3'd4,
    RST_WAIT = 3'd5,
    RUN      = 3'd6,
    FAULT    = 3'd7
  } state_t;

  localparam int MAX_A   = (STAGE_TMO > RST_DLY) ? STAGE_TMO : RST_DLY;
  localparam int MAX_B   = (RETRY_WAIT > MAX_RETRY) ? RETRY_WAIT : MAX_RETRY;
  localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [3:0] CODE_S5_TMO  = 4'd1;
  localparam logic [3:0] CODE_S3_TMO  = 4'd2;
  localparam logic [3:0] CODE_VRM_TMO = 4'd3;
  localparam logic [3:0] CODE_RUN_PG  = 4'd4;
  localparam logic [3:0] CODE_1V5_PG  = 4'd5;

  // Two-flop synchronizers for every asynchronous input.
  localparam int NS = 10;
  logic [NS-1:0] pin_raw;
  logic [NS-1:0] sync_a;
  logic [NS-1:0] sync_b;

  assign pin_raw = {bus.ctrl_signal, bus.SLP_S5n, bus.SLP_S3n, bus.V3V3_ALW_PWRGD,
                    bus.V1V5_PWRGD, bus.V1V8_PWRGD, bus.V1V_PWRGD,
                    bus.APU_VDD_PWRGD, bus.vrm_allow, bus.fault_clr};

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= pin_raw;
      sync_b <= sync_a;
    end
  end

  logic ctrl_s, s5_s, s3_s, pg3v3_s, pg1v5_s, pg1v8_s, pg1v_s, apu_s, vrm_s, clr_s;
  assign {ctrl_s, s5_s, s3_s, pg3v3_s, pg1v5_s, pg1v8_s, pg1v_s, apu_s, vrm_s, clr_s} = sync_b;

  state_t        st;
  state_t        st_nxt;
  logic [3:0]    code_nxt;
  logic [TW-1:0] tmr;
  logic          tmo_hit;
  logic          dly_hit;
  logic          rails_ok;
  logic          retry_go;

  assign tmo_hit  = (tmr == TW'(STAGE_TMO - 1));
  assign dly_hit  = (tmr == TW'(RST_DLY - 1));
  assign rails_ok = pg1v5_s && pg1v8_s && pg1v_s && apu_s;

`ifdef APU_PWR_RETRY_EN
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  assign retry_go = (tmr == TW'(RETRY_WAIT - 1)) && (retry_cnt < RW'(MAX_RETRY));
`else
  assign retry_go = 1'b0;
`endif

  // Ordering inside the sequencing states encodes the priority: control and
  // sleep requests first (so a sleep request masks a coincident PG drop),
  // then rail drops, then timeouts, then progression. A power-good arriving
  // on the timeout cycle takes the progression branch.
  always_comb begin
    st_nxt   = st;
    code_nxt = 4'd0;
    case (st)
      OFF: begin
        if (ctrl_s && pg3v3_s && s5_s) st_nxt = S5_EN;
      end
      FAULT: begin
        if (clr_s || retry_go) st_nxt = OFF;
      end
      default: begin
        if (!ctrl_s || !s5_s) begin
          st_nxt = OFF;
        end else if (!s3_s && (st >= S3_EN)) begin
          st_nxt = S5_OK;
        end else begin
          case (st)
            S5_EN: begin
              if (pg1v5_s) st_nxt = S5_OK;
              else if (tmo_hit) begin
                st_nxt   = FAULT;
                code_nxt = CODE_S5_TMO;
              end
            end
            S5_OK: begin
              if (!pg1v5_s) begin
                st_nxt   = FAULT;
                code_nxt = CODE_1V5_PG;
              end else if (s3_s) st_nxt = S3_EN;
            end
            S3_EN: begin
              if (!pg1v5_s) begin
                st_nxt   = FAULT;
                code_nxt = CODE_1V5_PG;
              end else if (pg1v8_s && pg1v_s) st_nxt = VRM_EN;
              else if (tmo_hit) begin
                st_nxt   = FAULT;
                code_nxt = CODE_S3_TMO;
              end
            end
            VRM_EN: begin
              if (!pg1v5_s) begin
                st_nxt   = FAULT;
                code_nxt = CODE_1V5_PG;
              end else if (apu_s) st_nxt = RST_WAIT;
              else if (tmo_hit) begin
                st_nxt   = FAULT;
                code_nxt = CODE_VRM_TMO;
              end
            end
            RST_WAIT: begin
              if (!rails_ok) begin
                st_nxt   = FAULT;
                code_nxt = CODE_RUN_PG;
              end else if (dly_hit) st_nxt = RUN;
            end
            RUN: begin
              if (!rails_ok) begin
                st_nxt   = FAULT;
                code_nxt = CODE_RUN_PG;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they switch on the
  // same edge as the state register (pin edge to output = 3 osc edges).
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      st                <= OFF;
      tmr               <= '0;
      bus.EN_1V5        <= 1'b0;
      bus.VRS_ON        <= 1'b0;
      bus.V1V8_EN       <= 1'b0;
      bus.APU_VRM_EN    <= 1'b0;
      bus.DISCHARGE_S5n <= 1'b0;
      bus.DISCHARGE_S3n <= 1'b0;
      bus.sys_pwrgd     <= 1'b0;
      bus.pwr_rstn      <= 1'b0;
      bus.state         <= 3'd0;
      bus.fault         <= 1'b0;
      bus.fault_code    <= 4'd0;
`ifdef APU_PWR_RETRY_EN
      retry_cnt         <= '0;
`endif
    end else begin
      st  <= st_nxt;
      tmr <= (st_nxt != st) ? '0 : tmr + TW'(1);

      bus.EN_1V5        <= (st_nxt >= S5_EN)  && (st_nxt <= RUN);
      bus.DISCHARGE_S5n <= (st_nxt >= S5_EN)  && (st_nxt <= RUN);
      bus.VRS_ON        <= (st_nxt >= S3_EN)  && (st_nxt <= RUN);
      bus.V1V8_EN       <= (st_nxt >= S3_EN)  && (st_nxt <= RUN);
      bus.DISCHARGE_S3n <= (st_nxt >= S3_EN)  && (st_nxt <= RUN);
      bus.APU_VRM_EN    <= (st_nxt >= VRM_EN) && (st_nxt <= RUN) && vrm_s;
      bus.sys_pwrgd     <= (st_nxt == RST_WAIT) || (st_nxt == RUN);
      bus.pwr_rstn      <= (st_nxt == RUN);
      bus.state         <= st_nxt;
      bus.fault         <= (st_nxt == FAULT);

      if ((st != FAULT) && (st_nxt == FAULT)) bus.fault_code <= code_nxt;
      else if ((st == FAULT) && (st_nxt != FAULT)) bus.fault_code <= 4'd0;

`ifdef APU_PWR_RETRY_EN
      if ((st == FAULT) && clr_s) retry_cnt <= '0;
      else if ((st == FAULT) && (st_nxt == OFF)) retry_cnt <= retry_cnt + RW'(1);
      else if ((st != RUN) && (st_nxt == RUN)) retry_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_apu_pwr_seq.sv
// tb_apu_pwr_seq
//   Self-checking bench for apu_pwr_seq with STAGE_TMO=16, RST_DLY=32,
//   RETRY_WAIT=8, MAX_RETRY=2. A board model raises each power-good four
//   cycles after its enable (with per-rail kill flags); a scoreboard checks
//   every state transition against an expected-state queue filled by the
//   scenario tasks. The retry scenario is built only with APU_PWR_RETRY_EN.
module tb_apu_pwr_seq;
  localparam int STAGE_TMO  = 16;
  localparam int RST_DLY    = 32;
  localparam int RETRY_WAIT = 8;
  localparam int MAX_RETRY  = 2;

  logic osc = 1'b0;
  logic rst = 1'b1;

  apu_pwr_seq_if bus();

  apu_pwr_seq #(
    .STAGE_TMO (STAGE_TMO),
    .RST_DLY   (RST_DLY),
    .RETRY_WAIT(RETRY_WAIT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .osc(osc),
    .rst(rst),
    .bus(bus)
  );

  always #5 osc = ~osc;

  int errors = 0;
  int checks = 0;

  // Board model: power-goods follow their enables by four osc cycles.
  logic [3:0] sr_1v5 = '0, sr_1v8 = '0, sr_1v = '0, sr_vdd = '0;
  bit kill_1v5 = 0, kill_1v8 = 0, kill_1v = 0, kill_vdd = 0;

  assign bus.V1V5_PWRGD    = sr_1v5[3] & ~kill_1v5;
  assign bus.V1V8_PWRGD    = sr_1v8[3] & ~kill_1v8;
  assign bus.V1V_PWRGD     = sr_1v[3]  & ~kill_1v;
  assign bus.APU_VDD_PWRGD = sr_vdd[3] & ~kill_vdd;

  initial begin
    forever begin
      @(negedge osc);
      if (rst) begin
        sr_1v5 = '0; sr_1v8 = '0; sr_1v = '0; sr_vdd = '0;
      end else begin
        sr_1v5 = {sr_1v5[2:0], bus.EN_1V5};
        sr_1v8 = {sr_1v8[2:0], bus.V1V8_EN};
        sr_1v  = {sr_1v[2:0],  bus.VRS_ON};
        sr_vdd = {sr_vdd[2:0], bus.APU_VRM_EN};
      end
    end
  end

  // Scoreboard of state transitions.
  logic [2:0] exp_q[$];
  logic [2:0] prev_state = 3'd0;

  initial begin
    logic [2:0] exp_s;
    forever begin
      @(negedge osc);
      if (rst) begin
        prev_state = bus.state;
      end else if (bus.state !== prev_state) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: state %0d (from %0d), required no transition", bus.state, prev_state);
        end else begin
          exp_s = exp_q.pop_front();
          if (bus.state !== exp_s) begin
            errors++;
            $display("FAIL sb_state: state %0d (from %0d), required %0d", bus.state, prev_state, exp_s);
          end
        end
        prev_state = bus.state;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.ctrl_signal    = 1'b0;
    bus.SLP_S5n        = 1'b0;
    bus.SLP_S3n        = 1'b0;
    bus.V3V3_ALW_PWRGD = 1'b0;
    bus.vrm_allow      = 1'b0;
    bus.fault_clr      = 1'b0;
    kill_1v5 = 0; kill_1v8 = 0; kill_1v = 0; kill_vdd = 0;
  endtask

  task automatic do_reset();
    @(negedge osc); #1;
    rst = 1'b1;
    drive_idle();
    exp_q.delete();
    repeat (2) @(negedge osc);
    #1;
    rst = 1'b0;
  endtask

  // Pushes expected states 1..last, then raises the power-up inputs.
  task automatic power_on(input int last);
    for (int i = 1; i <= last; i++) exp_q.push_back(3'(i));
    bus.ctrl_signal    = 1'b1;
    bus.V3V3_ALW_PWRGD = 1'b1;
    bus.SLP_S5n        = 1'b1;
    bus.SLP_S3n        = 1'b1;
    bus.vrm_allow      = 1'b1;
  endtask

  // Returns cycles waited, or -1 if the budget expired.
  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge osc); #1;
      n++;
    end while (bus.state !== s && n < budget);
    if (bus.state !== s) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge osc); #1;
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", bus.state); end
    checks++;
    if ({bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables: got %b required 0000", {bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN});
    end
    checks++;
    if ({bus.DISCHARGE_S5n, bus.DISCHARGE_S3n} !== 2'b00) begin
      errors++; $display("FAIL reset_discharge: got %b required 00", {bus.DISCHARGE_S5n, bus.DISCHARGE_S3n});
    end
    checks++;
    if ({bus.sys_pwrgd, bus.pwr_rstn, bus.fault} !== 3'b000) begin
      errors++; $display("FAIL reset_status: pwrgd/rstn/fault got %b required 000", {bus.sys_pwrgd, bus.pwr_rstn, bus.fault});
    end
    checks++;
    if (bus.fault_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d required 0", bus.fault_code); end
  endtask

  task automatic test_nominal();
    int n;
    do_reset();
    power_on(6);
    wait_state(3'd1, 20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL nom_latency: got %0d cycles required 3", n); end
    checks++;
    if (bus.EN_1V5 !== 1'b1 || bus.VRS_ON !== 1'b0) begin
      errors++; $display("FAIL nom_s5_en: EN_1V5=%b VRS_ON=%b required 1 0", bus.EN_1V5, bus.VRS_ON);
    end
    wait_state(3'd5, 200, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL nom_reach_rst_wait: state %0d required 5", bus.state); end
    checks++;
    if (bus.sys_pwrgd !== 1'b1 || bus.pwr_rstn !== 1'b0) begin
      errors++; $display("FAIL nom_rst_wait_out: sys_pwrgd=%b pwr_rstn=%b required 1 0", bus.sys_pwrgd, bus.pwr_rstn);
    end
    n = 0;
    while (bus.pwr_rstn !== 1'b1 && n < 100) begin
      @(negedge osc); #1;
      n++;
    end
    checks++;
    if (n !== RST_DLY) begin errors++; $display("FAIL nom_rst_dly: got %0d cycles required %0d", n, RST_DLY); end
    checks++;
    if ({bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n,
         bus.sys_pwrgd, bus.fault, bus.state} !== {8'b11111110, 3'd6}) begin
      errors++; $display("FAIL nom_run_out: state=%0d en=%b%b%b%b dis=%b%b pg=%b fault=%b required state 6 all on, fault 0",
        bus.state, bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n,
        bus.sys_pwrgd, bus.fault);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL nom_sb_drain: %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_s3_timeout();
    int n;
    do_reset();
    kill_1v8 = 1;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd7);
    power_on(0);
    wait_state(3'd3, 100, n);
    wait_state(3'd7, 100, n);
    checks++;
    if (n !== STAGE_TMO) begin errors++; $display("FAIL s3_tmo_cycles: got %0d required %0d", n, STAGE_TMO); end
    checks++;
    if (bus.fault_code !== 4'd2 || bus.fault !== 1'b1) begin
      errors++; $display("FAIL s3_tmo_code: code=%0d fault=%b required 2 1", bus.fault_code, bus.fault);
    end
    checks++;
    if ({bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n} !== 6'b0) begin
      errors++; $display("FAIL s3_tmo_outputs: en/dis got %b required 000000",
        {bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n});
    end
    bus.ctrl_signal = 1'b0;
    repeat (5) @(negedge osc);
    #1;
    checks++;
    if (bus.state !== 3'd7) begin errors++; $display("FAIL s3_fault_hold: state %0d required 7", bus.state); end
    exp_q.push_back(3'd0);
    bus.fault_clr = 1'b1;
    @(negedge osc); #1;
    bus.fault_clr = 1'b0;
    wait_state(3'd0, 20, n);
    checks++;
    if (n < 0 || bus.fault_code !== 4'd0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL s3_fault_clr: state=%0d code=%0d fault=%b required 0 0 0", bus.state, bus.fault_code, bus.fault);
    end
  endtask

  task automatic test_sleep_vs_drop();
    int n;
    do_reset();
    power_on(6);
    wait_state(3'd6, 200, n);
    exp_q.push_back(3'd2);
    kill_1v = 1;
    bus.SLP_S3n = 1'b0;
    wait_state(3'd2, 20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL slp_latency: got %0d cycles required 3 (state %0d)", n, bus.state); end
    checks++;
    if (bus.EN_1V5 !== 1'b1 || bus.VRS_ON !== 1'b0 || bus.fault !== 1'b0 || bus.pwr_rstn !== 1'b0 || bus.sys_pwrgd !== 1'b0) begin
      errors++; $display("FAIL slp_outputs: EN_1V5=%b VRS_ON=%b fault=%b rstn=%b pwrgd=%b required 1 0 0 0 0",
        bus.EN_1V5, bus.VRS_ON, bus.fault, bus.pwr_rstn, bus.sys_pwrgd);
    end
    repeat (10) @(negedge osc);
    #1;
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL slp_hold: state %0d required 2", bus.state); end
  endtask

  task automatic test_run_fault();
    int n;
    do_reset();
    power_on(6);
    wait_state(3'd6, 200, n);
    exp_q.push_back(3'd7);
    kill_vdd = 1;
    n = 0;
    while (bus.pwr_rstn !== 1'b0 && n < 10) begin
      @(negedge osc); #1;
      n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL run_pg_latency: got %0d cycles required 3", n); end
    checks++;
    if (bus.state !== 3'd7 || bus.fault_code !== 4'd4 || bus.fault !== 1'b1 || bus.sys_pwrgd !== 1'b0) begin
      errors++; $display("FAIL run_pg_fault: state=%0d code=%0d fault=%b pwrgd=%b required 7 4 1 0",
        bus.state, bus.fault_code, bus.fault, bus.sys_pwrgd);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    kill_vdd = 1;
    power_on(4);
    wait_state(3'd4, 100, n);
    checks++;
    if (n < 0 || bus.APU_VRM_EN !== 1'b1) begin
      errors++; $display("FAIL mid_reach_vrm: state=%0d APU_VRM_EN=%b required 4 1", bus.state, bus.APU_VRM_EN);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n,
         bus.sys_pwrgd, bus.pwr_rstn, bus.fault, bus.fault_code} !== 16'd0) begin
      errors++; $display("FAIL mid_async_reset: state=%0d en=%b%b%b%b dis=%b%b pg=%b rstn=%b fault=%b code=%0d required all 0",
        bus.state, bus.EN_1V5, bus.VRS_ON, bus.V1V8_EN, bus.APU_VRM_EN, bus.DISCHARGE_S5n, bus.DISCHARGE_S3n,
        bus.sys_pwrgd, bus.pwr_rstn, bus.fault, bus.fault_code);
    end
    @(negedge osc); #1;
    exp_q.delete();
    exp_q.push_back(3'd1);
    rst = 1'b0;
    wait_state(3'd1, 20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL mid_restart: got %0d cycles required 3", n); end
    @(negedge osc); #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_sb_drain: %0d pending required 0", exp_q.size()); end
  endtask

`ifdef APU_PWR_RETRY_EN
  task automatic test_retry();
    int n;
    do_reset();
    kill_1v5 = 1;
    for (int r = 0; r < MAX_RETRY; r++) begin
      exp_q.push_back(3'd1); exp_q.push_back(3'd7); exp_q.push_back(3'd0);
    end
    exp_q.push_back(3'd1); exp_q.push_back(3'd7);
    power_on(0);
    for (int r = 0; r < MAX_RETRY; r++) begin
      wait_state(3'd7, 100, n);
      wait_state(3'd0, 50, n);
      checks++;
      if (n !== RETRY_WAIT) begin errors++; $display("FAIL retry_dwell_%0d: got %0d cycles required %0d", r, n, RETRY_WAIT); end
    end
    wait_state(3'd7, 100, n);
    repeat (40) @(negedge osc);
    #1;
    checks++;
    if (bus.state !== 3'd7 || bus.fault_code !== 4'd1) begin
      errors++; $display("FAIL retry_exhausted: state=%0d code=%0d required 7 1", bus.state, bus.fault_code);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL retry_sb_drain: %0d pending required 0", exp_q.size()); end
    bus.ctrl_signal = 1'b0;
    exp_q.push_back(3'd0);
    bus.fault_clr = 1'b1;
    @(negedge osc); #1;
    bus.fault_clr = 1'b0;
    wait_state(3'd0, 20, n);
    checks++;
    if (n < 0 || bus.fault_code !== 4'd0) begin
      errors++; $display("FAIL retry_clr: state=%0d code=%0d required 0 0", bus.state, bus.fault_code);
    end
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_nominal();
    test_s3_timeout();
    test_sleep_vs_drop();
    test_run_fault();
    test_reset_mid();
`ifdef APU_PWR_RETRY_EN
    test_retry();
`endif
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
